char_mem_writer: RTL and testbench

- Fills the 8-entry character memory that the HEX display reader scans. Characters are entered one at a time on switches and committed with a pushbutton.
- Accepts only the eight display-decodable ASCII codes: A=65, b=98, C=67, d=100, E=69, F=70, g=103, h=104. Any other code sets an error flag and is not written.
- Writes go to an auto-incrementing pointer that wraps at DEPTH.
- Provides a clear sequence that blanks every location and rewinds the pointer.

---
 rtl/char_mem_writer_if.sv | 11 +
 rtl/char_mem_writer.sv | 171 +++++++++++++++++
 tb/tb_char_mem_writer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/char_mem_writer_if.sv
// Character memory write port: address, data and write enable driven by the writer.
interface char_mem_writer_if #(
    parameter int unsigned ADDR_WIDTH = 5
) ();
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_data;
    logic                  mem_wren;

    modport master (output mem_addr, output mem_data, output mem_wren);
    modport slave  (input  mem_addr, input  mem_data, input  mem_wren);
endinterface

// File: rtl/char_mem_writer.sv
// Fills the HEX display character memory from switches: validated single writes
// at an auto-incrementing, wrapping pointer, plus a clear sweep that blanks every
// location and rewinds the pointer.
module char_mem_writer #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 8,
    parameter logic [7:0]  BLANK      = 8'h00
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic [7:0]            Data,
    input  logic                  Write,
    input  logic                  Clear,
    char_mem_writer_if.master     mem,
    output logic                  Busy,
    output logic                  Error,
    output logic [ADDR_WIDTH:0]   Level
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      cptr_q, cptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  error_q, error_d;
    logic                  wren_q, wren_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  write_hist_q, clear_hist_q;

    logic                  write_req_c, clear_req_c, code_ok_c, clear_last_c;
    logic [PTR_W-1:0]      cptr_inc_c;

    // Only the eight codes the display reader can decode are accepted.
    function automatic logic is_valid_code(input logic [7:0] code);
        case (code)
            8'd65, 8'd98, 8'd67, 8'd100, 8'd69, 8'd70, 8'd103, 8'd104: is_valid_code = 1'b1;
            default:                                                   is_valid_code = 1'b0;
        endcase
    endfunction

    assign write_req_c  = Write & ~write_hist_q;
    assign clear_req_c  = Clear & ~clear_hist_q;
    assign code_ok_c    = is_valid_code(Data);
    assign clear_last_c = (cptr_q == PTR_W'(DEPTH - 1));
    assign cptr_inc_c   = cptr_q + PTR_W'(1);

    // State register; Busy is registered alongside so it tracks state != IDLE exactly.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; clear wins over a simultaneous write, requests while busy are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (clear_req_c) begin
                    state_d = S_CLEAR;
                end else if (write_req_c && code_ok_c) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_CLEAR: begin
                if (clear_last_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Next values for the registered memory port, pointers, level and error flag.
    always_comb begin
        wptr_d  = wptr_q;
        cptr_d  = cptr_q;
        level_d = level_q;
        error_d = error_q;
        wren_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (clear_req_c) begin
                    cptr_d  = '0;
                    error_d = 1'b0;
                    wren_d  = 1'b1;
                    addr_d  = '0;
                    data_d  = BLANK;
                end else if (write_req_c) begin
                    if (code_ok_c) begin
                        wren_d  = 1'b1;
                        addr_d  = ADDR_WIDTH'(wptr_q);
                        data_d  = Data;
                        error_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
                if (level_q < LVL_W'(DEPTH)) begin
                    level_d = level_q + LVL_W'(1);
                end
            end
            S_CLEAR: begin
                if (clear_last_c) begin
                    wptr_d  = '0;
                    level_d = '0;
                end else begin
                    cptr_d = cptr_inc_c;
                    wren_d = 1'b1;
                    addr_d = ADDR_WIDTH'(cptr_inc_c);
                    data_d = BLANK;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; edge-detect history resets high so a level held through reset is ignored.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wptr_q       <= '0;
            cptr_q       <= '0;
            level_q      <= '0;
            error_q      <= 1'b0;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            write_hist_q <= 1'b1;
            clear_hist_q <= 1'b1;
        end else begin
            wptr_q       <= wptr_d;
            cptr_q       <= cptr_d;
            level_q      <= level_d;
            error_q      <= error_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            write_hist_q <= Write;
            clear_hist_q <= Clear;
        end
    end

    assign mem.mem_addr = addr_q;
    assign mem.mem_data = data_q;
    assign mem.mem_wren = wren_q;
    assign Busy         = busy_q;
    assign Error        = error_q;
    assign Level        = level_q;

endmodule

// File: tb/tb_char_mem_writer.sv
// Bench for char_mem_writer: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level reference model.
module tb_char_mem_writer;

    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = AW + 1;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic [7:0]    Data;
    logic          Write;
    logic          Clear;
    logic          Busy;
    logic          Error;
    logic [LW-1:0] Level;

    char_mem_writer_if #(.ADDR_WIDTH(AW)) mem_if ();

    char_mem_writer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .BLANK(8'h00)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Data   (Data),
        .Write  (Write),
        .Clear  (Clear),
        .mem    (mem_if),
        .Busy   (Busy),
        .Error  (Error),
        .Level  (Level)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct {
        bit         w;
        bit         c;
        logic [7:0] d;
        int         nwr;
        int         addr;
        int         lvl;
        bit         err;
    } vec_t;

    wr_t        obs_q[$];
    int         busy_total = 0;
    int         checks     = 0;
    int         errors     = 0;
    logic [7:0] codes [8];

    // Monitor: log every memory write and every busy cycle.
    always @(negedge Clock) begin
        if (Resetn === 1'b1) begin
            if (mem_if.mem_wren === 1'b1) obs_q.push_back('{mem_if.mem_addr, mem_if.mem_data});
            if (Busy === 1'b1) busy_total++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] req_v);
        checks++;
        if (act_v !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act_v, req_v);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        Write  = 1'b0;
        Clear  = 1'b0;
        Data   = 8'h00;
        repeat (2) @(posedge Clock);
        #1 Resetn = 1'b1;
        tick();
    endtask

    // Raise Write/Clear for one cycle, scramble Data afterwards, then let any operation finish.
    task automatic pulse(input bit w, input bit c, input logic [7:0] d, output int s_obs, output int s_busy);
        s_obs  = obs_q.size();
        s_busy = busy_total;
        Data   = d;
        Write  = w;
        Clear  = c;
        tick();
        Write  = 1'b0;
        Clear  = 1'b0;
        Data   = 8'($urandom);
        repeat (DEPTH + 2) tick();
    endtask

    function automatic bit m_valid(input logic [7:0] d);
        foreach (codes[i]) if (codes[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    vec_t tbl [14];

    initial begin
        int s, sb, n;
        int m_wptr, m_level, eb, r;
        bit m_err, w, c;
        logic [7:0] d;
        wr_t exp_q[$];

        codes = '{8'd65, 8'd98, 8'd67, 8'd100, 8'd69, 8'd70, 8'd103, 8'd104};

        // write, clear, data, writes, first addr, level, error
        tbl[0]  = '{1, 0,  65, 1, 0, 1, 0};
        tbl[1]  = '{1, 0,  98, 1, 1, 2, 0};
        tbl[2]  = '{1, 0,  67, 1, 2, 3, 0};
        tbl[3]  = '{1, 0, 100, 1, 3, 4, 0};
        tbl[4]  = '{1, 0,  69, 1, 4, 5, 0};
        tbl[5]  = '{1, 0,  70, 1, 5, 6, 0};
        tbl[6]  = '{1, 0, 103, 1, 6, 7, 0};
        tbl[7]  = '{1, 0, 104, 1, 7, 8, 0};
        tbl[8]  = '{1, 0,  65, 1, 0, 8, 0};
        tbl[9]  = '{1, 0,  90, 0, 0, 8, 1};
        tbl[10] = '{1, 0,  67, 1, 1, 8, 0};
        tbl[11] = '{0, 1,   0, 8, 0, 0, 0};
        tbl[12] = '{1, 0,  69, 1, 0, 1, 0};
        tbl[13] = '{1, 1, 100, 8, 0, 0, 0};

        // Reset values
        do_reset();
        chk("rst_wren",  32'(mem_if.mem_wren), 32'd0);
        chk("rst_addr",  32'(mem_if.mem_addr), 32'd0);
        chk("rst_data",  32'(mem_if.mem_data), 32'd0);
        chk("rst_busy",  32'(Busy),  32'd0);
        chk("rst_error", 32'(Error), 32'd0);
        chk("rst_level", 32'(Level), 32'd0);

        // Basic write latency, cycle by cycle
        Data  = 8'd65;
        Write = 1'b1;
        tick();
        chk("lat_wren", 32'(mem_if.mem_wren), 32'd1);
        chk("lat_addr", 32'(mem_if.mem_addr), 32'd0);
        chk("lat_data", 32'(mem_if.mem_data), 32'd65);
        chk("lat_busy", 32'(Busy), 32'd1);
        Write = 1'b0;
        tick();
        chk("lat_wren_off", 32'(mem_if.mem_wren), 32'd0);
        chk("lat_busy_off", 32'(Busy),  32'd0);
        chk("lat_level",    32'(Level), 32'd1);
        chk("lat_error",    32'(Error), 32'd0);

        // Directed vector table
        do_reset();
        for (int k = 0; k < 14; k++) begin
            pulse(tbl[k].w, tbl[k].c, tbl[k].d, s, sb);
            n = obs_q.size() - s;
            chk($sformatf("vec%0d_nwr", k), 32'(n), 32'(tbl[k].nwr));
            chk($sformatf("vec%0d_busy", k), 32'(busy_total - sb), 32'(tbl[k].nwr));
            if (n == tbl[k].nwr && n == 1) begin
                chk($sformatf("vec%0d_addr", k), 32'(obs_q[s].addr), 32'(tbl[k].addr));
                chk($sformatf("vec%0d_data", k), 32'(obs_q[s].data), 32'(tbl[k].d));
            end
            if (n == tbl[k].nwr && n == 8) begin
                for (int i = 0; i < 8; i++)
                    chk($sformatf("vec%0d_clr%0d", k, i), 32'(obs_q[s+i]), 32'({5'(i), 8'h00}));
            end
            chk($sformatf("vec%0d_level", k), 32'(Level), 32'(tbl[k].lvl));
            chk($sformatf("vec%0d_error", k), 32'(Error), 32'(tbl[k].err));
        end

        // Write edges (valid and invalid) during a clear are dropped
        s  = obs_q.size();
        Clear = 1'b1; tick(); Clear = 1'b0;
        tick(); tick();
        Data = 8'd67; Write = 1'b1; tick(); Write = 1'b0;
        Data = 8'd90; tick();
        Write = 1'b1; tick(); Write = 1'b0;
        repeat (8) tick();
        n = obs_q.size() - s;
        chk("busydrop_nwr", 32'(n), 32'd8);
        if (n == 8)
            for (int i = 0; i < 8; i++) chk($sformatf("busydrop_clr%0d", i), 32'(obs_q[s+i]), 32'({5'(i), 8'h00}));
        chk("busydrop_level", 32'(Level), 32'd0);
        chk("busydrop_error", 32'(Error), 32'd0);

        // Reset in the middle of a clear
        pulse(1'b1, 1'b0, 8'd104, s, sb);
        chk("midrst_pre_level", 32'(Level), 32'd1);
        s = obs_q.size();
        Clear = 1'b1; tick(); Clear = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (obs_q.size() - s >= 4) break;
            @(negedge Clock);
        end
        chk("midrst_reached", 32'(obs_q.size() - s >= 4), 32'd1);
        #2 Resetn = 1'b0;
        #1;
        chk("midrst_wren",  32'(mem_if.mem_wren), 32'd0);
        chk("midrst_addr",  32'(mem_if.mem_addr), 32'd0);
        chk("midrst_data",  32'(mem_if.mem_data), 32'd0);
        chk("midrst_busy",  32'(Busy),  32'd0);
        chk("midrst_level", 32'(Level), 32'd0);
        chk("midrst_error", 32'(Error), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        tick();
        pulse(1'b1, 1'b0, 8'd98, s, sb);
        n = obs_q.size() - s;
        chk("midrst_next_nwr", 32'(n), 32'd1);
        if (n == 1) chk("midrst_next_wr", 32'(obs_q[s]), 32'({5'd0, 8'd98}));
        chk("midrst_next_level", 32'(Level), 32'd1);

        // Write held high across reset release does not trigger
        Resetn = 1'b0;
        Data   = 8'd65;
        Write  = 1'b1;
        Clear  = 1'b0;
        repeat (2) @(posedge Clock);
        #1 Resetn = 1'b1;
        s  = obs_q.size();
        sb = busy_total;
        repeat (4) tick();
        Write = 1'b0;
        repeat (2) tick();
        chk("heldrst_nwr",   32'(obs_q.size() - s), 32'd0);
        chk("heldrst_busy",  32'(busy_total - sb),  32'd0);
        chk("heldrst_level", 32'(Level), 32'd0);

        // Randomized operations against the reference model
        do_reset();
        m_wptr  = 0;
        m_level = 0;
        m_err   = 1'b0;
        for (int k = 0; k < 150; k++) begin
            exp_q.delete();
            r = $urandom_range(0, 19);
            w = 1'b0;
            c = 1'b0;
            d = 8'($urandom);
            if (r < 2)      c = 1'b1;
            else if (r < 3) begin c = 1'b1; w = 1'b1; end
            else if (r < 7) w = 1'b1;
            else begin w = 1'b1; d = codes[$urandom_range(0, 7)]; end

            if (c) begin
                for (int i = 0; i < int'(DEPTH); i++) exp_q.push_back('{AW'(i), 8'h00});
                m_wptr = 0; m_level = 0; m_err = 1'b0; eb = DEPTH;
            end else if (m_valid(d)) begin
                exp_q.push_back('{AW'(m_wptr), d});
                m_wptr  = (m_wptr + 1) % DEPTH;
                m_level = (m_level < int'(DEPTH)) ? m_level + 1 : int'(DEPTH);
                m_err   = 1'b0;
                eb      = 1;
            end else begin
                m_err = 1'b1;
                eb    = 0;
            end

            pulse(w, c, d, s, sb);
            n = obs_q.size() - s;
            chk($sformatf("rnd%0d_nwr", k), 32'(n), 32'(exp_q.size()));
            for (int i = 0; i < n && i < exp_q.size(); i++)
                chk($sformatf("rnd%0d_wr%0d", k, i), 32'(obs_q[s+i]), 32'(exp_q[i]));
            chk($sformatf("rnd%0d_busy", k),  32'(busy_total - sb), 32'(eb));
            chk($sformatf("rnd%0d_level", k), 32'(Level), 32'(m_level));
            chk($sformatf("rnd%0d_error", k), 32'(Error), 32'(m_err));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
